mem_write_sequencer: RTL
========================

MEM_WRITE_SEQUENCER -- requirements
Module: mem_write_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL set word-address width; RAM depth is 2^ADDR_WIDTH 32-bit words.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-low (0 = reset asserted).
REQ-004 address  input  32  SHALL be the byte address of the access from the core.
REQ-005 write  input  2  SHALL be the write request: 00 none, 01 byte, 10 halfword, 11 word.
REQ-006 wdata  input  32  SHALL carry write data, right-justified (byte in [7:0], halfword in [15:0]).
REQ-007 rdata  output  32  SHALL be the RAM word at address[ADDR_WIDTH+1:2], one cycle after address is presented.
REQ-008 done  output  1  SHALL be write-complete status, held until write returns to 00.
REQ-009 error  output  1  SHALL flag a rejected access (misaligned or out-of-range).
REQ-010 ram_addr  output  ADDR_WIDTH  SHALL be the word address to the synchronous single-port RAM.
REQ-011 ram_wdata  output  32  SHALL be the merged word written to RAM.
REQ-012 ram_we  output  1  SHALL be the RAM write strobe, active high, one cycle per write.
REQ-013 ram_q  input  32  SHALL be RAM read data, valid one cycle after ram_addr.

Function
REQ-014 Byte lanes SHALL be big-endian: byte offset k = address[1:0] occupies word bits [31-8k:24-8k]; halfword offset 0 occupies [31:16], offset 2 occupies [15:0].
REQ-015 FSM states SHALL be IDLE, READ_OLD, WRITE, DONE.
REQ-016 In IDLE, ram_addr SHALL equal address[ADDR_WIDTH+1:2]; rdata SHALL equal ram_q at all times.
REQ-017 In IDLE with write != 00, the block SHALL latch address, write and wdata; later changes to these inputs SHALL NOT affect the operation in progress.
REQ-018 Misaligned request (halfword with address[0]=1, word with address[1:0]!=00) SHALL go IDLE -> DONE with error=1 and no ram_we pulse.
REQ-019 Out-of-range request (any of address[31:ADDR_WIDTH+2] nonzero) SHALL go IDLE -> DONE with error=1 and no ram_we pulse.
REQ-020 Legal byte/halfword request SHALL go IDLE -> READ_OLD -> WRITE -> DONE; READ_OLD drives latched word address to fetch the old word.
REQ-021 In WRITE after READ_OLD, ram_wdata SHALL be ram_q with only the addressed lane(s) replaced by wdata; other lanes unchanged; ram_we=1 for exactly that cycle.
REQ-022 Legal word request SHALL go IDLE -> WRITE -> DONE with ram_wdata = latched wdata, no read.
REQ-023 Latency: done SHALL rise 3 cycles after acceptance for byte/half, 2 for word, 1 for rejected requests.
REQ-024 In DONE, done=1; the FSM SHALL stay in DONE while write != 00 and go to IDLE on the first cycle write == 00; done SHALL be 0 in all other states.
REQ-025 error SHALL be registered: set on entry to DONE for a rejected request, cleared on the next acceptance of a legal request; it SHALL NOT change while in DONE.
REQ-026 A request held asserted through DONE SHALL NOT cause a second RAM write.
REQ-027 ram_we SHALL be 0 in IDLE, READ_OLD and DONE.
REQ-028 Unreachable state encodings SHALL return to IDLE on the next clock.

Reset
REQ-029 On rst=0, asynchronously: state=IDLE, done=0, error=0, ram_we=0, latched address/size/data=0.
REQ-030 rst asserted mid-operation (READ_OLD or WRITE) SHALL abort with no ram_we pulse after reset assertion; the RAM word keeps its prior value.
REQ-031 After rst deasserts with write != 00, the block SHALL accept the request as a new one on the next edge.

Verification
REQ-032 RAM[1]=0x11223344; byte write address=0x5, wdata=0xAA -> ram_we once, RAM[1]=0x11AA3344, done high 3 cycles after acceptance.
REQ-033 RAM[2]=0xDEADBEEF; halfword write address=0xA, wdata=0x1234 -> RAM[2]=0xDEAD1234; halfword at 0x9 -> error=1, done=1, no ram_we, RAM unchanged.
REQ-034 Word write address=0x0, wdata=0xCAFEF00D, held 5 cycles in DONE -> exactly one ram_we, done=1 throughout DONE, IDLE one cycle after write=00.
REQ-035 ADDR_WIDTH=10, word write address=0x00001000 -> error=1, done=1, no ram_we; next legal write clears error.
REQ-036 Read: address=0xC with RAM[3]=0x01020304, write=00 -> rdata=0x01020304 one cycle later, done=0, ram_we=0.
REQ-037 Byte write, rst=0 during READ_OLD -> done=0, error=0, no ram_we, RAM word unchanged; request re-accepted after reset release.

Source files
------------

// File: rtl/mem_write_sequencer.sv
// Sub-word write sequencer in front of a synchronous single-port 32-bit RAM.
// Byte and halfword writes do read-modify-write (big-endian lanes). Word
// writes go straight to the RAM. Misaligned or out-of-range requests are
// rejected without touching the RAM.
module mem_write_sequencer #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           address,
  input  logic [1:0]            write,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  output logic                  ram_we,
  input  logic [31:0]           ram_q
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] READ_OLD = 2'd1;
  localparam logic [1:0] WRITE    = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH+1:0] addr_q,  addr_d;
  logic [1:0]            size_q,  size_d;
  logic [31:0]           data_q,  data_d;
  logic                  err_q,   err_d;

  logic misaligned;
  logic out_of_range;

  // Replace the addressed lane(s) of old_word; byte offset 0 is the MSB lane.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  offset);
    logic [31:0] w;
    w = old_word;
    case (size)
      SZ_BYTE: begin
        case (offset)
          2'd0:    w[31:24] = new_data[7:0];
          2'd1:    w[23:16] = new_data[7:0];
          2'd2:    w[15:8]  = new_data[7:0];
          default: w[7:0]   = new_data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (offset[1]) w[15:0]  = new_data[15:0];
        else           w[31:16] = new_data[15:0];
      end
      default: w = new_data;
    endcase
    return w;
  endfunction

  // Classify the incoming request; only meaningful while IDLE.
  always_comb begin
    misaligned   = ((write == SZ_HALF) && address[0]) ||
                   ((write == SZ_WORD) && (address[1:0] != 2'b00));
    out_of_range = ((address >> (ADDR_WIDTH + 2)) != 32'd0);
  end

  // Next-state and request-latch logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (write != SZ_NONE) begin
          addr_d = address[ADDR_WIDTH+1:0];
          size_d = write;
          data_d = wdata;
          if (misaligned || out_of_range) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = (write == SZ_WORD) ? WRITE : READ_OLD;
          end
        end
      end
      READ_OLD: state_d = WRITE;
      WRITE:    state_d = DONE;
      DONE: begin
        // Stay here while the core holds the request so it is written once.
        if (write == SZ_NONE) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  // State and latched-request registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= SZ_NONE;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // RAM port and status outputs; the old word arrives on ram_q during WRITE.
  always_comb begin
    ram_addr  = (state_q == IDLE) ? address[ADDR_WIDTH+1:2] : addr_q[ADDR_WIDTH+1:2];
    ram_we    = (state_q == WRITE);
    ram_wdata = merge_lanes(ram_q, data_q, size_q, addr_q[1:0]);
    done      = (state_q == DONE);
    error     = err_q;
    rdata     = ram_q;
  end

endmodule
